// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
//   mem_op_e     : memory op codes as driven on m<i>_op / mem_write_en
//   lock_state_e : ownership FSM states (IDLE, OWN0, OWN1)
//   MEM_SIZE     : first byte address outside the data memory
//   is_store()   : true for SB/SH/SW
package dmem_pkg;

  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LBU = 3'b011,
    MEM_LHU = 3'b100,
    MEM_SB  = 3'b101,
    MEM_SH  = 3'b110,
    MEM_SW  = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_state_e;

  // Held at 64 bits so the range check works for any address width up to 64.
  localparam logic [63:0] MEM_SIZE = 64'h0000_0000_0002_0000;

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant register.
//   clk, rst_n : clock and asynchronous active-low reset
//   req_i[1:0] : requests (already masked by any lock blocking)
//   gnt_o[1:0] : one-hot (or zero) combinational grant
// On contention the port that was not granted most recently wins. The
// last-grant register resets to port 1 so port 0 wins the first contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // last_q == 1 means port 1 was granted last, so port 0 has priority.
  assign gnt_o[0] = req_i[0] & (~req_i[1] | last_q);
  assign gnt_o[1] = req_i[1] & (~req_i[0] | ~last_q);

  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = 1'b0;
    end else if (gnt_o[1]) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with bus locking and access checking.
//   clk, rst_n                : clock, asynchronous active-low reset
//   m<i>_req/op/addr/wdata/lock : requester i transaction inputs
//   m<i>_gnt                  : combinational accept for requester i
//   m<i>_rvalid/rdata/err     : registered response, one cycle after grant
//   mem_address/data_in/write_en, mem_data_out : data-memory port
// A locked transaction gives its port exclusive ownership until it issues an
// unlocked transaction or LOCK_MAX cycles pass without it being accepted.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int LOCK_MAX      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     m0_req,
  input  logic [2:0]               m0_op,
  input  logic [ADDRESS_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0]    m0_wdata,
  input  logic                     m0_lock,
  output logic                     m0_gnt,
  output logic                     m0_rvalid,
  output logic [DATA_WIDTH-1:0]    m0_rdata,
  output logic                     m0_err,
  input  logic                     m1_req,
  input  logic [2:0]               m1_op,
  input  logic [ADDRESS_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0]    m1_wdata,
  input  logic                     m1_lock,
  output logic                     m1_gnt,
  output logic                     m1_rvalid,
  output logic [DATA_WIDTH-1:0]    m1_rdata,
  output logic                     m1_err,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_in,
  output logic [2:0]               mem_write_en,
  input  logic [DATA_WIDTH-1:0]    mem_data_out
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  lock_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] req_w;
  logic [1:0] block_w;
  logic [1:0] gnt_w;
  logic       any_gnt;

  mem_op_e                  sel_op;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;
  logic                     misaligned;
  logic                     out_of_range;
  logic                     txn_err;
  logic [DATA_WIDTH-1:0]    resp_data;

  // The owner's partner is masked before arbitration, so the owner is never
  // starved by a round-robin pick that would land on a blocked port.
  assign req_w      = {m1_req, m0_req};
  assign block_w[0] = (state_q == OWN1);
  assign block_w[1] = (state_q == OWN0);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_w & ~block_w),
    .gnt_o (gnt_w)
  );

  assign m0_gnt  = gnt_w[0];
  assign m1_gnt  = gnt_w[1];
  assign any_gnt = |gnt_w;

  assign sel_op    = mem_op_e'(gnt_w[1] ? m1_op : m0_op);
  assign sel_addr  = gnt_w[1] ? m1_addr : m0_addr;
  assign sel_wdata = gnt_w[1] ? m1_wdata : m0_wdata;

  always_comb begin
    misaligned = 1'b0;
    case (sel_op)
      MEM_LH, MEM_LHU, MEM_SH: misaligned = sel_addr[0];
      MEM_LW, MEM_SW:          misaligned = |sel_addr[1:0];
      default:                 misaligned = 1'b0;
    endcase
  end

  assign out_of_range = (64'(sel_addr) >= MEM_SIZE);
  assign txn_err      = misaligned | out_of_range;

  // Error transactions still reach the memory port, but as a harmless load.
  assign mem_address  = any_gnt ? sel_addr : '0;
  assign mem_data_in  = any_gnt ? sel_wdata : '0;
  assign mem_write_en = (any_gnt && !txn_err) ? sel_op : 3'b000;

  assign resp_data = (txn_err || is_store(sel_op)) ? '0 : mem_data_out;

  // Ownership FSM and idle-cycle counter for the current lock holder.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_w[0] && m0_lock) begin
          state_d = OWN0;
        end else if (gnt_w[1] && m1_lock) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if ((state_q == OWN0) ? gnt_w[0] : gnt_w[1]) begin
          cnt_d = '0;
          if (!((state_q == OWN0) ? m0_lock : m1_lock)) begin
            state_d = IDLE;
          end
        end else if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
          // This idle cycle is the LOCK_MAX-th: drop ownership silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-port response registers: rvalid/err pulse, rdata holds between pulses.
  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    logic                  rvalid_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= gnt_w[gi];
        err_q    <= gnt_w[gi] & txn_err;
        if (gnt_w[gi]) begin
          rdata_q <= resp_data;
        end
      end
    end
  end

  assign m0_rvalid = g_resp[0].rvalid_q;
  assign m0_err    = g_resp[0].err_q;
  assign m0_rdata  = g_resp[0].rdata_q;
  assign m1_rvalid = g_resp[1].rvalid_q;
  assign m1_err    = g_resp[1].err_q;
  assign m1_rdata  = g_resp[1].rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameters: ADDRESS_WIDTH, default 32, byte-address width; DATA_WIDTH, default 32, data width; LOCK_MAX, default 16, idle-cycle limit while a port holds the lock.
REQ-002 The block SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have, for each port i in {0,1}, `m<i>_req`, input, 1 bit: requester i has a transaction pending.
REQ-005 The block SHALL have `m<i>_op`, input, 3 bits: memory op code (000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW).
REQ-006 The block SHALL have `m<i>_addr`, input, ADDRESS_WIDTH: byte address.
REQ-007 The block SHALL have `m<i>_wdata`, input, DATA_WIDTH: store data.
REQ-008 The block SHALL have `m<i>_lock`, input, 1 bit: keep ownership after this transaction.
REQ-009 The block SHALL have `m<i>_gnt`, output, 1 bit: transaction accepted this cycle.
REQ-010 The block SHALL have `m<i>_rvalid`, output, 1 bit: response pulse.
REQ-011 The block SHALL have `m<i>_rdata`, output, DATA_WIDTH: load data.
REQ-012 The block SHALL have `m<i>_err`, output, 1 bit: response is an error.
REQ-013 The block SHALL have `mem_address`, output, ADDRESS_WIDTH; `mem_data_in`, output, DATA_WIDTH; `mem_write_en`, output, 3 bits; `mem_data_out`, input, DATA_WIDTH: the data-memory port.

Function
REQ-014 m<i>_gnt SHALL be combinational: m<i>_req high, port i selected by arbitration, and port i not blocked by the other port's lock.
REQ-015 With no lock held and both ports requesting, the port not granted most recently SHALL win; last-grant resets to port 1, so port 0 wins first.
REQ-016 With one port requesting, that port SHALL be granted in the same cycle (zero-wait).
REQ-017 During an accepted cycle, mem_address, mem_data_in and mem_write_en SHALL equal the granted port's addr, wdata and op.
REQ-018 In a cycle with no grant, the memory port SHALL drive address 0, data 0 and write_en 000; write_en 000 is a non-writing load.
REQ-019 Every accepted transaction SHALL produce exactly one m<i>_rvalid pulse one cycle after the grant.
REQ-020 For a load, m<i>_rdata SHALL be registered mem_data_out from the grant cycle.
REQ-021 For a store, m<i>_rdata SHALL be 0; rdata SHALL hold its value between pulses.
REQ-022 A transaction SHALL be an error when LH/LHU/SH has addr[0]=1, LW/SW has addr[1:0]!=0, or addr >= MEM_SIZE (0x20000).
REQ-023 An error transaction SHALL be granted but SHALL force mem_write_en to 000.
REQ-024 An error response SHALL be rvalid=1, err=1, rdata=0.
REQ-025 The FSM SHALL have states IDLE, OWN0 and OWN1.
REQ-026 An accepted transaction with m<i>_lock=1 SHALL move the FSM to OWNi.
REQ-027 In OWNi, m<j>_gnt SHALL be 0 for the other port j.
REQ-028 In OWNi, an accepted transaction of port i with lock=0 SHALL return the FSM to IDLE.
REQ-029 In OWNi, a counter SHALL count cycles without a port-i acceptance and reset to 0 on each acceptance; reaching LOCK_MAX SHALL force IDLE.
REQ-030 The lock timeout SHALL not flag an error, and the counter SHALL clear whenever the FSM enters IDLE.
REQ-031 Requests SHALL be evaluated every cycle; back-to-back grants to the same port are legal when the other port is idle.

Reset
REQ-032 While rst_n=0, the FSM SHALL be IDLE, last-grant port 1, lock counter 0, and all rvalid, err and rdata 0, asynchronously.
REQ-033 Reset asserted in a grant cycle SHALL discard that response: no rvalid after reset release.

Structure
REQ-034 Package dmem_pkg SHALL hold the op-code enum (MEM_LB..MEM_SW), the state enum and MEM_SIZE.
REQ-035 A sub-module rr_arb2 (two-way round-robin with last-grant register) SHALL implement the arbitration.
REQ-036 The lock FSM, error check and response registers SHALL reside in dmem_arbiter.

Verification
REQ-037 Both ports LW, addr 0x10000 / 0x10004, held 2 cycles -> gnt order m0 then m1; each rvalid 1 cycle later with memory contents.
REQ-038 m0 SW 0xDEADBEEF @0x10008, then m1 LW @0x10008 -> m1_rdata=0xDEADBEEF, err=0.
REQ-039 m1 LH @0x10001 -> gnt=1, mem_write_en=000, next cycle rvalid=1, err=1, rdata=0.
REQ-040 m0 LW lock=1, then m1 req continuous -> m1_gnt=0 until m0 issues lock=0, or 16 idle cycles elapse in OWN0.
REQ-041 m0 SW @0x20000 -> err=1 and memory unchanged.
REQ-042 rst_n low in a grant cycle -> rvalid=0 next cycle, FSM IDLE, m0 wins next contention.
